// File: rtl/stack_driver.sv
// Request/response front end for an external 4-bit-wide hardware stack.
// Translates PUSH/POP/PEEK/ADD/SUB/CLEAR requests into stack bus cycles.
module stack_driver #(
    parameter int unsigned DEPTH = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [2:0] REQ_OP,
    input  logic [3:0] REQ_DATA,
    input  logic [2:0] REQ_INDEX,
    output logic       RSP_VALID,
    output logic [3:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic [3:0] DEPTH_CNT,
    output logic [1:0] S_COMMAND,
    output logic [2:0] S_INDEX,
    output logic [3:0] S_DATA,
    output logic       S_RESET,
    input  logic [3:0] S_RDATA
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_POP_A, ST_POP_B, ST_CAPTURE, ST_PUSH_R, ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'b000,
        OP_POP   = 3'b001,
        OP_PEEK  = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_CLEAR = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        CMD_NOP = 2'b00, CMD_PUSH = 2'b01, CMD_POP = 2'b10, CMD_GET = 2'b11
    } cmd_e;

    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_e     r_state, w_state;
    logic [2:0] r_op, w_op;
    logic [3:0] r_a, w_a;
    logic       r_ready, w_ready;
    logic       r_rsp_valid, w_rsp_valid;
    logic [3:0] r_rsp_data, w_rsp_data;
    logic       r_rsp_err, w_rsp_err;
    logic [3:0] r_depth, w_depth;
    cmd_e       r_scmd, w_scmd;
    logic [2:0] r_sidx, w_sidx;
    logic [3:0] r_sdata, w_sdata;
    logic       r_sreset, w_sreset;

    logic       w_accept;
    logic       w_err;
    logic [3:0] w_result;

    assign w_accept = REQ_VALID && r_ready;
    // b is the entry arriving now, a was popped first (the old top)
    assign w_result = (r_op == OP_ADD) ? (S_RDATA + r_a) : (S_RDATA - r_a);

    always_comb begin
        w_err = 1'b0;
        case (REQ_OP)
            OP_PUSH:          w_err = (r_depth >= DEPTH_L);
            OP_POP:           w_err = (r_depth == 4'd0);
            OP_PEEK:          w_err = ({1'b0, REQ_INDEX} >= r_depth);
            OP_ADD, OP_SUB:   w_err = (r_depth < 4'd2);
            OP_CLEAR:         w_err = 1'b0;
            default:          w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_a         = r_a;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_data  = r_rsp_data;
        w_depth     = r_depth;
        w_scmd      = CMD_NOP;
        w_sidx      = r_sidx;
        w_sdata     = r_sdata;
        w_sreset    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_op = REQ_OP;
                    if (w_err) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_data  = '0;
                        w_state     = ST_RESP;
                    end else begin
                        case (REQ_OP)
                            OP_PUSH: begin
                                w_scmd  = CMD_PUSH;
                                w_sdata = REQ_DATA;
                                w_state = ST_ISSUE;
                            end
                            OP_POP: begin
                                w_scmd  = CMD_POP;
                                w_state = ST_ISSUE;
                            end
                            OP_PEEK: begin
                                w_scmd  = CMD_GET;
                                w_sidx  = REQ_INDEX;
                                w_state = ST_ISSUE;
                            end
                            OP_ADD, OP_SUB: begin
                                w_scmd  = CMD_POP;
                                w_state = ST_POP_A;
                            end
                            default: begin
                                w_sreset = 1'b1;
                                w_state  = ST_ISSUE;
                            end
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                case (r_op)
                    OP_PUSH: begin
                        w_depth     = r_depth + 4'd1;
                        w_rsp_valid = 1'b1;
                        w_rsp_data  = r_sdata;
                        w_state     = ST_RESP;
                    end
                    OP_POP: begin
                        w_depth = r_depth - 4'd1;
                        w_state = ST_CAPTURE;
                    end
                    OP_PEEK: begin
                        w_state = ST_CAPTURE;
                    end
                    default: begin
                        w_depth     = '0;
                        w_rsp_valid = 1'b1;
                        w_rsp_data  = '0;
                        w_state     = ST_RESP;
                    end
                endcase
            end
            ST_POP_A: begin
                w_depth = r_depth - 4'd1;
                w_scmd  = CMD_POP;
                w_state = ST_POP_B;
            end
            ST_POP_B: begin
                w_depth = r_depth - 4'd1;
                w_a     = S_RDATA;
                w_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (r_op == OP_ADD || r_op == OP_SUB) begin
                    w_scmd  = CMD_PUSH;
                    w_sdata = w_result;
                    w_state = ST_PUSH_R;
                end else begin
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = S_RDATA;
                    w_state     = ST_RESP;
                end
            end
            ST_PUSH_R: begin
                w_depth     = r_depth + 4'd1;
                w_rsp_valid = 1'b1;
                w_rsp_data  = r_sdata;
                w_state     = ST_RESP;
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Ready waits one extra edge after any stack clear has been released
        w_ready = (w_state == ST_IDLE) && !r_sreset && !w_sreset;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_depth     <= '0;
            r_scmd      <= CMD_NOP;
            r_sidx      <= '0;
            r_sdata     <= '0;
            r_sreset    <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_a         <= w_a;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_depth     <= w_depth;
            r_scmd      <= w_scmd;
            r_sidx      <= w_sidx;
            r_sdata     <= w_sdata;
            r_sreset    <= w_sreset;
        end
    end

    assign REQ_READY = r_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ERR   = r_rsp_err;
    assign DEPTH_CNT = r_depth;
    assign S_COMMAND = r_scmd;
    assign S_INDEX   = r_sidx;
    assign S_DATA    = r_sdata;
    assign S_RESET   = r_sreset;

endmodule

// File: tb/tb_stack_driver.sv
// Directed bench for stack_driver with a behavioural stack and a response scoreboard.
module tb_stack_driver;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [2:0] REQ_OP = '0;
    logic [3:0] REQ_DATA = '0;
    logic [2:0] REQ_INDEX = '0;
    logic       RSP_VALID;
    logic [3:0] RSP_DATA;
    logic       RSP_ERR;
    logic [3:0] DEPTH_CNT;
    logic [1:0] S_COMMAND;
    logic [2:0] S_INDEX;
    logic [3:0] S_DATA;
    logic       S_RESET;
    logic [3:0] S_RDATA = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       err;
        logic [3:0] data;
        int         lat;
        logic [3:0] depth;
        logic       cmd;
        int         sres;
    } exp_t;

    exp_t sb[$];

    stack_driver #(.DEPTH(5)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_DATA(REQ_DATA), .REQ_INDEX(REQ_INDEX),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .DEPTH_CNT(DEPTH_CNT), .S_COMMAND(S_COMMAND), .S_INDEX(S_INDEX),
        .S_DATA(S_DATA), .S_RESET(S_RESET), .S_RDATA(S_RDATA)
    );

    always #5 CLK = ~CLK;

    // Attached stack: samples the bus on the rising edge, read data registered
    logic [3:0] mem [8];
    int sp = 0;
    always @(posedge CLK) begin
        if (S_RESET) begin
            sp <= 0;
        end else begin
            case (S_COMMAND)
                2'b01: if (sp < 8) begin mem[3'(sp)] <= S_DATA; sp <= sp + 1; end
                2'b10: if (sp > 0) begin S_RDATA <= mem[3'(sp - 1)]; sp <= sp - 1; end
                2'b11: if (sp - 1 - int'(S_INDEX) >= 0) S_RDATA <= mem[3'(sp - 1 - int'(S_INDEX))];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] op, input logic [3:0] data, input logic [2:0] idx,
                          input logic err, input logic [3:0] rdata, input int lat,
                          input logic [3:0] depth, input logic cmd, input int sres);
        exp_t e;
        exp_t got;
        int guard = 0;
        int k = 0;
        bit seen = 0;
        bit cmd_seen = 0;
        int sres_cnt = 0;
        e.err = err; e.data = rdata; e.lat = lat; e.depth = depth; e.cmd = cmd; e.sres = sres;
        sb.push_back(e);
        while (REQ_READY !== 1'b1 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 16'(REQ_READY), 16'd1);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_DATA = data; REQ_INDEX = idx;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0; REQ_OP = 3'b110; REQ_DATA = 4'hF; REQ_INDEX = 3'd7;
        while (!seen && k < 20) begin
            @(negedge CLK);
            if (S_COMMAND !== 2'b00) cmd_seen = 1;
            if (S_RESET === 1'b1) sres_cnt++;
            if (RSP_VALID === 1'b1) begin
                seen = 1;
                chk("sb_nonempty", 16'(sb.size() > 0), 16'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk("latency", 16'(k), 16'(got.lat));
                    chk("rsp_err", 16'(RSP_ERR), 16'(got.err));
                    chk("rsp_data", 16'(RSP_DATA), 16'(got.data));
                    chk("depth", 16'(DEPTH_CNT), 16'(got.depth));
                    chk("cmd_issued", 16'(cmd_seen), 16'(got.cmd));
                    chk("sreset_cycles", 16'(sres_cnt), 16'(got.sres));
                end
            end else begin
                k++;
            end
        end
        if (!seen) chk("rsp_timeout", 16'(seen), 16'd1);
        @(negedge CLK);
        chk("rsp_strobe", 16'(RSP_VALID), 16'd0);
        chk("ready_after", 16'(REQ_READY), 16'd1);
        chk("rsp_hold", 16'(RSP_DATA), 16'(rdata));
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_ready", 16'(REQ_READY), 16'd0);
        chk("rst_rsp_valid", 16'(RSP_VALID), 16'd0);
        chk("rst_rsp_err", 16'(RSP_ERR), 16'd0);
        chk("rst_rsp_data", 16'(RSP_DATA), 16'd0);
        chk("rst_depth", 16'(DEPTH_CNT), 16'd0);
        chk("rst_scmd", 16'(S_COMMAND), 16'd0);
        chk("rst_sidx", 16'(S_INDEX), 16'd0);
        chk("rst_sdata", 16'(S_DATA), 16'd0);
        chk("rst_sreset", 16'(S_RESET), 16'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("rel_sreset", 16'(S_RESET), 16'd0);
        chk("rel_ready0", 16'(REQ_READY), 16'd0);
        @(posedge CLK); #1;
        chk("rel_ready1", 16'(REQ_READY), 16'd1);
        @(negedge CLK);

        // Fill to capacity, then overflow
        for (int i = 1; i <= 5; i++)
            do_req(3'b000, 4'(i), 3'd0, 1'b0, 4'(i), 1, 4'(i), 1'b1, 0);
        do_req(3'b000, 4'd6, 3'd0, 1'b1, 4'd0, 0, 4'd5, 1'b0, 0);

        // PEEK every slot, then one past the end
        for (int i = 0; i < 5; i++)
            do_req(3'b010, 4'd0, 3'(i), 1'b0, 4'(5 - i), 2, 4'd5, 1'b1, 0);
        do_req(3'b010, 4'd0, 3'd5, 1'b1, 4'd0, 0, 4'd5, 1'b0, 0);

        // Arithmetic with wrap-around
        do_req(3'b101, 4'd0, 3'd0, 1'b0, 4'd0, 1, 4'd0, 1'b0, 1);
        do_req(3'b000, 4'd9, 3'd0, 1'b0, 4'd9, 1, 4'd1, 1'b1, 0);
        do_req(3'b000, 4'd8, 3'd0, 1'b0, 4'd8, 1, 4'd2, 1'b1, 0);
        do_req(3'b011, 4'd0, 3'd0, 1'b0, 4'd1, 4, 4'd1, 1'b1, 0);
        do_req(3'b000, 4'd3, 3'd0, 1'b0, 4'd3, 1, 4'd2, 1'b1, 0);
        do_req(3'b100, 4'd0, 3'd0, 1'b0, 4'd14, 4, 4'd1, 1'b1, 0);

        // Drain, then error cases on an empty stack
        do_req(3'b001, 4'd0, 3'd0, 1'b0, 4'd14, 2, 4'd0, 1'b1, 0);
        do_req(3'b001, 4'd0, 3'd0, 1'b1, 4'd0, 0, 4'd0, 1'b0, 0);
        do_req(3'b011, 4'd0, 3'd0, 1'b1, 4'd0, 0, 4'd0, 1'b0, 0);
        do_req(3'b111, 4'd0, 3'd0, 1'b1, 4'd0, 0, 4'd0, 1'b0, 0);
        do_req(3'b010, 4'd0, 3'd0, 1'b1, 4'd0, 0, 4'd0, 1'b0, 0);

        // Reset asserted while the second pop of an ADD is on the bus
        do_req(3'b000, 4'd2, 3'd0, 1'b0, 4'd2, 1, 4'd1, 1'b1, 0);
        do_req(3'b000, 4'd7, 3'd0, 1'b0, 4'd7, 1, 4'd2, 1'b1, 0);
        REQ_VALID = 1'b1; REQ_OP = 3'b011;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("midop_second_pop", 16'(S_COMMAND), 16'd2);
        RESET = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_rsp_valid", 16'(RSP_VALID), 16'd0);
            chk("abort_depth", 16'(DEPTH_CNT), 16'd0);
            chk("abort_sreset", 16'(S_RESET), 16'd1);
            @(negedge CLK);
        end
        RESET = 1'b1;
        do_req(3'b001, 4'd0, 3'd0, 1'b1, 4'd0, 0, 4'd0, 1'b0, 0);

        // CLEAR a populated stack and reuse it
        do_req(3'b000, 4'd2, 3'd0, 1'b0, 4'd2, 1, 4'd1, 1'b1, 0);
        do_req(3'b000, 4'd7, 3'd0, 1'b0, 4'd7, 1, 4'd2, 1'b1, 0);
        do_req(3'b101, 4'd0, 3'd0, 1'b0, 4'd0, 1, 4'd0, 1'b0, 1);
        do_req(3'b000, 4'd4, 3'd0, 1'b0, 4'd4, 1, 4'd1, 1'b1, 0);
        do_req(3'b001, 4'd0, 3'd0, 1'b0, 4'd4, 2, 4'd0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
